// File: rtl/mlp_pkg.sv
// Shared types and default widths for the MLP neuron datapath.
package mlp_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int FRAC_W_DEF = 8;
    localparam int ACC_W_DEF  = 40;

    typedef logic signed [DATA_W_DEF-1:0] data_t;
    typedef logic signed [ACC_W_DEF-1:0]  acc_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } act_state_e;

endpackage

// File: rtl/neuron_act_sat.sv
// Combinational round-half-up, arithmetic shift by FRAC_W and saturation
// of a bias-adjusted accumulator sum down to the DATA_W activation format.
module neuron_act_sat
    import mlp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic signed [ACC_W:0]    sum_i,
    output logic signed [DATA_W-1:0] value_o,
    output logic                     sat_o
);

    // One extra bit of headroom so adding the rounding constant cannot overflow.
    localparam int SW = ACC_W + 2;
    localparam logic [SW-1:0] HALF = {{(SW-1){1'b0}}, 1'b1} << (FRAC_W - 1);

    logic signed [SW-1:0] rnd_s;
    logic signed [SW-1:0] shf_s;

    // Round, shift, then clip anything whose upper bits are not pure sign extension.
    always_comb begin
        rnd_s   = {sum_i[ACC_W], sum_i} + HALF;
        shf_s   = rnd_s >>> FRAC_W;
        value_o = shf_s[DATA_W-1:0];
        sat_o   = 1'b0;
        if (!shf_s[SW-1] && (|shf_s[SW-2:DATA_W-1])) begin
            value_o = {1'b0, {(DATA_W-1){1'b1}}};
            sat_o   = 1'b1;
        end else if (shf_s[SW-1] && !(&shf_s[SW-2:DATA_W-1])) begin
            value_o = {1'b1, {(DATA_W-1){1'b0}}};
            sat_o   = 1'b1;
        end else begin
            value_o = shf_s[DATA_W-1:0];
            sat_o   = 1'b0;
        end
    end

endmodule

// File: rtl/neuron_act_writer.sv
// Bias-add, round/saturate, ReLU and sequential BRAM write of neuron results.
// Optional saturation counter enabled by defining NEURON_ACT_SAT_CNT_EN.
module neuron_act_writer
    import mlp_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int FRAC_W  = FRAC_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int NEURONS = 784,
    parameter int ADDR_W  = 10
) (
    input  logic              pi_clk,
    input  logic              pi_rst,
    input  logic              pi_layer_start,
    input  logic              pi_acc_valid,
    input  logic [ACC_W-1:0]  pi_acc_data,
    input  logic [DATA_W-1:0] pi_bias,
    output logic              po_BRAM_we,
    output logic [ADDR_W-1:0] po_BRAM_add,
    output logic [DATA_W-1:0] po_BRAM_data,
    output logic              po_busy,
    output logic              po_layer_done,
    output logic              po_drop,
    output logic [15:0]       po_sat_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NEURONS - 1);

    act_state_e state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic drop_q, drop_d;
    logic busy_q, done_q;

    logic accept_s;
    logic start_s;
    logic signed [ACC_W:0] acc_ext_s, bias_ext_s, sum_s;
    logic signed [DATA_W-1:0] sat_val_s;
    logic sat_s;

    logic                     s1_valid_q;
    logic signed [ACC_W:0]    s1_sum_q;
    logic [ADDR_W-1:0]        s1_addr_q;
    logic                     s2_valid_q;
    logic signed [DATA_W-1:0] s2_data_q;
    logic [ADDR_W-1:0]        s2_addr_q;
    logic                     we_q;
    logic [ADDR_W-1:0]        add_q;
    logic [DATA_W-1:0]        data_q;

    assign accept_s   = (state_q == RUN) && pi_acc_valid;
    assign start_s    = (state_q == IDLE) && pi_layer_start;
    assign acc_ext_s  = {pi_acc_data[ACC_W-1], pi_acc_data};
    assign bias_ext_s = {{(ACC_W+1-DATA_W){pi_bias[DATA_W-1]}}, pi_bias} << FRAC_W;
    assign sum_s      = acc_ext_s + bias_ext_s;

    neuron_act_sat #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_sat (
        .sum_i   (s1_sum_q),
        .value_o (sat_val_s),
        .sat_o   (sat_s)
    );

    // Layer FSM next-state, neuron address counter and sticky drop flag.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;
        case (state_q)
            IDLE: begin
                if (pi_layer_start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    drop_d  = pi_acc_valid;
                end else begin
                    drop_d  = drop_q | pi_acc_valid;
                end
            end
            RUN: begin
                if (pi_acc_valid && (cnt_q == LAST_ADDR)) begin
                    state_d = DRAIN;
                end else if (pi_acc_valid) begin
                    cnt_d   = cnt_q + ADDR_W'(1);
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                drop_d = drop_q | pi_acc_valid;
                if (!s1_valid_q && !s2_valid_q) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                drop_d  = drop_q | pi_acc_valid;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and control/status registers.
    always_ff @(posedge pi_clk) begin
        if (pi_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    // Three-stage datapath: bias add, round/saturate, ReLU and BRAM write.
    always_ff @(posedge pi_clk) begin
        if (pi_rst) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_addr_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_addr_q  <= '0;
            we_q       <= 1'b0;
            add_q      <= '0;
            data_q     <= '0;
        end else begin
            s1_valid_q <= accept_s;
            if (accept_s) begin
                s1_sum_q  <= sum_s;
                s1_addr_q <= cnt_q;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q <= sat_val_s;
                s2_addr_q <= s1_addr_q;
            end
            we_q <= s2_valid_q;
            if (s2_valid_q) begin
                add_q  <= s2_addr_q;
                data_q <= s2_data_q[DATA_W-1] ? '0 : s2_data_q;
            end
        end
    end

`ifdef NEURON_ACT_SAT_CNT_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;

    // Saturating count of clip events seen at the round/saturate stage.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (start_s) begin
            sat_cnt_d = 16'h0000;
        end else if (s1_valid_q && sat_s && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'h0001;
        end else begin
            sat_cnt_d = sat_cnt_q;
        end
    end

    // Saturation counter register.
    always_ff @(posedge pi_clk) begin
        if (pi_rst) begin
            sat_cnt_q <= 16'h0000;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign po_sat_count = sat_cnt_q;
`else
    logic sat_unused_s;
    assign sat_unused_s = sat_s | start_s;
    assign po_sat_count = 16'h0000;
`endif

    assign po_BRAM_we    = we_q;
    assign po_BRAM_add   = add_q;
    assign po_BRAM_data  = data_q;
    assign po_busy       = busy_q;
    assign po_layer_done = done_q;
    assign po_drop       = drop_q;

endmodule

// File: tb/tb_neuron_act_writer.sv
// Directed table-driven bench for neuron_act_writer with a 4-neuron layer.
module tb_neuron_act_writer;

    logic        clk = 1'b0;
    logic        rst, layer_start, acc_valid;
    logic [39:0] acc_data;
    logic [15:0] bias;
    logic        we, busy, done, drop;
    logic [9:0]  add;
    logic [15:0] data, sat_count;

    neuron_act_writer #(.NEURONS(4)) dut (
        .pi_clk         (clk),
        .pi_rst         (rst),
        .pi_layer_start (layer_start),
        .pi_acc_valid   (acc_valid),
        .pi_acc_data    (acc_data),
        .pi_bias        (bias),
        .po_BRAM_we     (we),
        .po_BRAM_add    (add),
        .po_BRAM_data   (data),
        .po_busy        (busy),
        .po_layer_done  (done),
        .po_drop        (drop),
        .po_sat_count   (sat_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [9:0]  wr_add_q[$];
    logic [15:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          done_cyc = -1;
    int          busy_fall_cyc = -1;
    logic        busy_prev = 1'b0;

    always @(negedge clk) begin
        if (we) begin
            wr_add_q.push_back(add);
            wr_data_q.push_back(data);
            wr_cyc_q.push_back(cyc);
        end
        if (done) done_cyc = cyc;
        if (busy_prev && !busy) busy_fall_cyc = cyc;
        busy_prev = busy;
    end

    typedef struct {
        logic [39:0] acc;
        logic [15:0] bias;
        logic [15:0] exp_data;
    } vec_t;

    vec_t tbl[8];
    int   n_vec = 0;
    int   n_err = 0;
    int   iss[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_add_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        done_cyc      = -1;
        busy_fall_cyc = -1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && busy; i++) tick();
        chk("idle_wait", busy, 0);
    endtask

    task automatic check_layer(input int base, input int exp_sat);
        chk("n_writes", wr_add_q.size(), 4);
        for (int j = 0; j < 4 && j < wr_add_q.size(); j++) begin
            chk($sformatf("addr[%0d]", base + j), wr_add_q[j], j);
            chk($sformatf("data[%0d]", base + j), wr_data_q[j], tbl[base + j].exp_data);
            chk($sformatf("lat[%0d]", base + j), wr_cyc_q[j], iss[j] + 3);
        end
        chk("done_cyc", done_cyc, iss[3] + 4);
        chk("busy_fall", busy_fall_cyc, iss[3] + 5);
        chk("sat_count", sat_count, exp_sat);
        chk("drop_clear", drop, 0);
    endtask

    task automatic run_table_layer(input int base, input int exp_sat);
        wait_idle();
        clear_mon();
        layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
        for (int j = 0; j < 4; j++) begin
            acc_valid = 1'b1;
            acc_data  = tbl[base + j].acc;
            bias      = tbl[base + j].bias;
            iss[j]    = cyc;
            tick();
        end
        acc_valid = 1'b0;
        repeat (8) tick();
`ifdef NEURON_ACT_SAT_CNT_EN
        check_layer(base, exp_sat);
`else
        check_layer(base, 0);
`endif
    endtask

    task automatic send_simple(input int j);
        acc_valid = 1'b1;
        acc_data  = 40'(j * 256);
        bias      = 16'h0000;
        tick();
        acc_valid = 1'b0;
    endtask

    initial begin
        tbl[0] = '{40'h00_0001_8000, 16'h0040, 16'h01C0};
        tbl[1] = '{-40'sd131072,     16'h0000, 16'h0000};
        tbl[2] = '{40'h00_0000_0080, 16'h0000, 16'h0001};
        tbl[3] = '{40'd13107200,     16'h0000, 16'h7FFF};
        tbl[4] = '{40'h00_0001_0000, 16'hFF80, 16'h0080};
        tbl[5] = '{-40'sd13107200,   16'h0000, 16'h0000};
        tbl[6] = '{40'h00_007F_FF00, 16'h0000, 16'h7FFF};
        tbl[7] = '{40'h00_007F_FF80, 16'h0000, 16'h7FFF};

        rst = 1'b1; layer_start = 1'b0; acc_valid = 1'b0;
        acc_data = 40'h0; bias = 16'h0;
        repeat (3) tick();
        chk("rst_we", we, 0);
        chk("rst_add", add, 0);
        chk("rst_data", data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_drop", drop, 0);
        chk("rst_sat", sat_count, 0);
        rst = 1'b0;
        tick();

        run_table_layer(0, 1);
        run_table_layer(4, 2);

        // Valid while idle is dropped; next start clears the flag.
        clear_mon();
        acc_valid = 1'b1; tick(); acc_valid = 1'b0; tick();
        chk("drop_idle", drop, 1);
        repeat (4) tick();
        chk("idle_no_write", wr_add_q.size(), 0);
        layer_start = 1'b1; tick(); layer_start = 1'b0;
        chk("drop_cleared", drop, 0);
        chk("busy_run", busy, 1);

        // Start while busy is ignored; valid in DRAIN is dropped.
        send_simple(1);
        send_simple(2);
        layer_start = 1'b1; tick(); layer_start = 1'b0;
        send_simple(3);
        send_simple(4);
        send_simple(5);
        repeat (8) tick();
        chk("busy_start_writes", wr_add_q.size(), 4);
        for (int j = 0; j < 4 && j < wr_add_q.size(); j++) begin
            chk($sformatf("busy_start_addr[%0d]", j), wr_add_q[j], j);
            chk($sformatf("busy_start_data[%0d]", j), wr_data_q[j], j + 1);
        end
        chk("drop_drain", drop, 1);

        // Start together with valid in idle: start wins, valid dropped.
        wait_idle();
        clear_mon();
        layer_start = 1'b1; acc_valid = 1'b1; acc_data = 40'h0000_0100;
        tick();
        layer_start = 1'b0; acc_valid = 1'b0;
        chk("start_valid_drop", drop, 1);
        chk("start_valid_busy", busy, 1);
        repeat (4) tick();
        chk("start_valid_no_write", wr_add_q.size(), 0);
        for (int j = 0; j < 4; j++) send_simple(j);
        repeat (8) tick();
        chk("sv_layer_writes", wr_add_q.size(), 4);
        layer_start = 1'b1; tick(); layer_start = 1'b0;
        chk("drop_next_start", drop, 0);

        // Reset with two results in flight.
        clear_mon();
        send_simple(7);
        send_simple(8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (6) tick();
        chk("rst_inflight_writes", wr_add_q.size(), 0);
        chk("rst2_we", we, 0);
        chk("rst2_add", add, 0);
        chk("rst2_data", data, 0);
        chk("rst2_busy", busy, 0);
        chk("rst2_done", done, 0);
        chk("rst2_drop", drop, 0);
        chk("rst2_sat", sat_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
